// File: rtl/elevator_call_scheduler.sv
// SCAN-policy call scheduler for one elevator car over NB_FLOORS floors.
// Hall calls are latched into a pending set. The car runs IDLE -> MOVE -> DOOR_OPEN.
// All outputs are flops loaded from the next-state values.
// Optional macro ELEVATOR_SCHED_ASSERT_EN compiles embedded SVA checks.
module elevator_call_scheduler #(
    parameter int NB_FLOORS     = 4,
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NB_FLOORS-1:0] call_i,
    output logic [NB_FLOORS-1:0] floor_o,
    output logic                 open_o,
    output logic                 move_up_o,
    output logic                 move_down_o,
    output logic                 dir_up_o,
    output logic [NB_FLOORS-1:0] pending_o
);
    localparam int CW = $clog2(NB_FLOORS);
    localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, MOVE, DOOR_OPEN} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cur, cur_nxt, arr;
    logic                 dir_nxt;
    logic [TW-1:0]        tcnt, tcnt_nxt;
    logic [DW-1:0]        dcnt, dcnt_nxt;
    logic [NB_FLOORS-1:0] clear, pending_nxt;

    // Any pending call strictly beyond floor f in the given direction.
    function automatic logic ahead(input logic [NB_FLOORS-1:0] p, input int f, input logic up);
        ahead = 1'b0;
        for (int i = 0; i < NB_FLOORS; i++)
            if ((up && i > f) || (!up && i < f)) ahead = ahead | p[i];
    endfunction

    function automatic logic [NB_FLOORS-1:0] onehot(input logic [CW-1:0] f);
        onehot    = '0;
        onehot[f] = 1'b1;
    endfunction

    // Next-state: SCAN sequencing, travel/door counters and pending update.
    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        dir_nxt   = dir_up_o;
        tcnt_nxt  = tcnt;
        dcnt_nxt  = dcnt;
        arr       = dir_up_o ? cur + CW'(1) : cur - CW'(1);
        unique case (state)
            IDLE: begin
                if (pending_o[cur]) begin
                    state_nxt = DOOR_OPEN;
                    dcnt_nxt  = DW'(DOOR_CYCLES - 1);
                end else if (ahead(pending_o, int'(cur), dir_up_o)) begin
                    state_nxt = MOVE;
                    tcnt_nxt  = TW'(TRAVEL_CYCLES - 1);
                end else if (ahead(pending_o, int'(cur), !dir_up_o)) begin
                    // Nothing left in this sweep: reverse and depart on the same edge.
                    dir_nxt   = !dir_up_o;
                    state_nxt = MOVE;
                    tcnt_nxt  = TW'(TRAVEL_CYCLES - 1);
                end
            end
            MOVE: begin
                if (tcnt == '0) begin
                    cur_nxt = arr;
                    if (pending_o[arr]) begin
                        state_nxt = DOOR_OPEN;
                        dcnt_nxt  = DW'(DOOR_CYCLES - 1);
                    end else if (ahead(pending_o, int'(arr), dir_up_o)) begin
                        tcnt_nxt = TW'(TRAVEL_CYCLES - 1);
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    tcnt_nxt = tcnt - TW'(1);
                end
            end
            DOOR_OPEN: begin
                // A call to this floor while open keeps the door open longer.
                if (call_i[cur])        dcnt_nxt  = DW'(DOOR_CYCLES - 1);
                else if (dcnt == '0)    state_nxt = IDLE;
                else                    dcnt_nxt  = dcnt - DW'(1);
            end
            default: state_nxt = IDLE;
        endcase
        clear       = (state_nxt == DOOR_OPEN) ? onehot(cur_nxt) : '0;
        pending_nxt = (pending_o | call_i) & ~clear;
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            cur         <= '0;
            tcnt        <= '0;
            dcnt        <= '0;
            dir_up_o    <= 1'b1;
            pending_o   <= '0;
            floor_o     <= NB_FLOORS'(1);
            open_o      <= 1'b0;
            move_up_o   <= 1'b0;
            move_down_o <= 1'b0;
        end else begin
            state       <= state_nxt;
            cur         <= cur_nxt;
            tcnt        <= tcnt_nxt;
            dcnt        <= dcnt_nxt;
            dir_up_o    <= dir_nxt;
            pending_o   <= pending_nxt;
            floor_o     <= onehot(cur_nxt);
            open_o      <= (state_nxt == DOOR_OPEN);
            move_up_o   <= (state_nxt == MOVE) && dir_nxt;
            move_down_o <= (state_nxt == MOVE) && !dir_nxt;
        end
    end

`ifdef ELEVATOR_SCHED_ASSERT_EN
    localparam int CLR_BOUND = NB_FLOORS * (TRAVEL_CYCLES + DOOR_CYCLES + 1) * 2;
    logic arrive;
    assign arrive = (state == MOVE) && (tcnt == '0);

    a_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot(floor_o));
    a_open_move: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(open_o && (move_up_o || move_down_o)));
    a_up_down: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(move_up_o && move_down_o));
    a_floor_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !$past(arrive) |-> $stable(floor_o));
    a_door_min: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $rose(open_o) |-> open_o [* DOOR_CYCLES]);
    for (genvar g = 0; g < NB_FLOORS; g++) begin : g_clr
        a_clr: assert property (@(posedge clk_i) disable iff (!rst_ni)
            $rose(pending_o[g]) |-> ##[1:CLR_BOUND] !pending_o[g]);
    end
`endif
endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Scoreboard bench: stimulus pushes the expected sequence of output segments
// (floor/open/up/down/dir plus duration); a monitor pops one per output change.
module tb_elevator_call_scheduler;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] call;
    logic [3:0] floor_o, pending_o;
    logic       open_o, move_up_o, move_down_o, dir_up_o;

    int checks   = 0;
    int failures = 0;

    elevator_call_scheduler #(.NB_FLOORS(4), .TRAVEL_CYCLES(8), .DOOR_CYCLES(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .call_i(call), .floor_o(floor_o), .open_o(open_o),
        .move_up_o(move_up_o), .move_down_o(move_down_o), .dir_up_o(dir_up_o),
        .pending_o(pending_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] fl;
        logic       op, up, dn, dr;
        int         len;   // 0: duration not checked
    } seg_t;

    seg_t exp_q[$];
    logic mon_en = 1'b0;
    logic [7:0] prev_t, cur_t;
    int run_len = 0;
    int seg_no  = 0;

    // Monitor: on every output change, close the running segment and score it.
    always @(negedge clk) begin
        cur_t = {floor_o, open_o, move_up_o, move_down_o, dir_up_o};
        if (!mon_en) begin
            prev_t  = cur_t;
            run_len = 0;
        end else if (cur_t != prev_t) begin
            seg_t e;
            checks++;
            seg_no++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL seg%0d unexpected: got=%h len=%0d, none expected", seg_no, prev_t, run_len);
            end else begin
                e = exp_q.pop_front();
                if ({e.fl, e.op, e.up, e.dn, e.dr} != prev_t || (e.len != 0 && e.len != run_len)) begin
                    failures++;
                    $display("FAIL seg%0d got=%h len=%0d exp=%h len=%0d", seg_no, prev_t, run_len,
                             {e.fl, e.op, e.up, e.dn, e.dr}, e.len);
                end
            end
            prev_t  = cur_t;
            run_len = 1;
        end else begin
            run_len++;
        end
    end

    task automatic push(input int f, input logic op, input logic up, input logic dn,
                        input logic dr, input int len);
        seg_t s;
        logic [3:0] one = 4'b0001;
        s.fl = one << f; s.op = op; s.up = up; s.dn = dn; s.dr = dr; s.len = len;
        exp_q.push_back(s);
    endtask
    task automatic idle(input int f, input logic dr, input int len); push(f, 0, 0, 0, dr, len); endtask
    task automatic door(input int f, input logic dr, input int len); push(f, 1, 0, 0, dr, len); endtask
    task automatic mv_up(input int f); push(f, 0, 1, 0, 1, 8); endtask
    task automatic mv_dn(input int f); push(f, 0, 0, 1, 0, 8); endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // One-cycle pulse, issued and returning on a negedge.
    task automatic pulse(input logic [3:0] v);
        call = v;
        @(negedge clk);
        call = 4'b0000;
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: got=%0d segments left exp=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        call  = 4'b0000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst_floor", floor_o, 4'b0001);
        chk("rst_open", open_o, 0);
        chk("rst_up", move_up_o, 0);
        chk("rst_down", move_down_o, 0);
        chk("rst_dir", dir_up_o, 1);
        chk("rst_pending", pending_o, 0);
        mon_en = 1'b1;

        // Call at the current floor: door opens one edge after latching.
        idle(0, 1, 0); door(0, 1, 4);
        pulse(4'b0001);
        chk("self_pending", pending_o, 4'b0001);
        wait_empty("self_call");
        chk("self_cleared", pending_o, 0);

        // All floors from floor 0 going up: served in order, no reversal.
        idle(0, 1, 0); door(0, 1, 4); idle(0, 1, 1);
        mv_up(0); door(1, 1, 4); idle(1, 1, 1);
        mv_up(1); door(2, 1, 4); idle(2, 1, 1);
        mv_up(2); door(3, 1, 4);
        pulse(4'b1111);
        chk("all_pending", pending_o, 4'b1111);
        wait_empty("all_calls");
        chk("all_cleared", pending_o, 0);

        // Reverse from floor 3 down to floor 1.
        idle(3, 1, 0); mv_dn(3); mv_dn(2); door(1, 0, 4);
        pulse(4'b0010);
        wait_empty("to_floor1");

        // Moving up 1->3, calls for 0 and 2 arrive mid-travel.
        idle(1, 0, 0); mv_up(1); door(2, 1, 4); idle(2, 1, 1);
        mv_up(2); door(3, 1, 4); idle(3, 1, 1);
        mv_dn(3); mv_dn(2); mv_dn(1); door(0, 0, 4);
        pulse(4'b1000);
        repeat (2) @(negedge clk);
        pulse(4'b0001);
        @(negedge clk);
        pulse(4'b0100);
        chk("sweep_pending", pending_o, 4'b1101);
        wait_empty("sweep");
        chk("sweep_cleared", pending_o, 0);

        // Door held open at floor 2 by three re-calls, 3 cycles apart.
        idle(0, 0, 0); mv_up(0); mv_up(1); door(2, 1, 13);
        pulse(4'b0100);
        begin
            int n = 0;
            while (!open_o && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("hold_reached_open", open_o, 1);
        end
        for (int k = 0; k < 3; k++) begin
            repeat (2) @(negedge clk);
            pulse(4'b0100);
            chk("hold_open", open_o, 1);
            chk("hold_no_pending", pending_o[2], 0);
        end
        wait_empty("door_hold");
        chk("hold_cleared", pending_o, 0);

        // Back to floor 0, then a long single-call run to floor 3.
        idle(2, 1, 0); mv_dn(2); mv_dn(1); door(0, 0, 4);
        pulse(4'b0001);
        wait_empty("back_to_0");
        idle(0, 0, 0); mv_up(0); mv_up(1); mv_up(2); door(3, 1, 4);
        pulse(4'b1000);
        wait_empty("run_to_3");
        chk("run_cleared", pending_o, 0);

        // Asynchronous reset in the middle of a move.
        mon_en = 1'b0;
        pulse(4'b0001);
        repeat (10) @(negedge clk);
        chk("pre_rst_moving", move_down_o, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_floor", floor_o, 4'b0001);
        chk("arst_open", open_o, 0);
        chk("arst_up", move_up_o, 0);
        chk("arst_down", move_down_o, 0);
        chk("arst_dir", dir_up_o, 1);
        chk("arst_pending", pending_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_floor", floor_o, 4'b0001);
        chk("post_rst_down", move_down_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
